// File: rtl/dff_pipe_line.sv
// Stallable WIDTH x DEPTH valid/data delay line; latency DEPTH advancing edges, en=0 holds, no backpressure.
// Define PIPE_PARITY_EN to carry an even-parity bit per stage and report output corruption on out_perr.
module dff_pipe_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             err_inj,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [OCC_W-1:0] occ,
  output logic             out_perr
);

  logic [DEPTH-1:0]            vld;
  logic [DEPTH-1:0]            vld_nxt;
  logic [DEPTH-1:0][WIDTH-1:0] dat;
  logic [DEPTH-1:0][WIDTH-1:0] dat_nxt;
  logic [OCC_W-1:0]            occ_nxt;

  always_comb begin
    vld_nxt = vld;
    dat_nxt = dat;
    if (clr) begin
      vld_nxt = '0;
      dat_nxt = '0;
    end else if (en) begin
      // Data is captured regardless of in_valid; only the valid bit qualifies it.
      vld_nxt[0] = in_valid;
      dat_nxt[0] = in_data;
      for (int k = 1; k < DEPTH; k++) begin
        vld_nxt[k] = vld[k-1];
        dat_nxt[k] = dat[k-1];
      end
    end
  end

  // Popcount of the next-state valid vector keeps occ aligned with vld.
  always_comb begin
    occ_nxt = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occ_nxt = occ_nxt + OCC_W'(vld_nxt[k]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      dat <= '0;
      occ <= '0;
    end else begin
      vld <= vld_nxt;
      dat <= dat_nxt;
      occ <= occ_nxt;
    end
  end

  assign out_valid = vld[DEPTH-1];
  assign out_data  = dat[DEPTH-1];

`ifdef PIPE_PARITY_EN
  logic [DEPTH-1:0] par;
  logic [DEPTH-1:0] par_nxt;
  logic             perr_nxt;

  always_comb begin
    par_nxt = par;
    if (clr) begin
      par_nxt = '0;
    end else if (en) begin
      par_nxt[0] = (^in_data) ^ err_inj;
      for (int k = 1; k < DEPTH; k++) begin
        par_nxt[k] = par[k-1];
      end
    end
    perr_nxt = vld_nxt[DEPTH-1] & (par_nxt[DEPTH-1] != (^dat_nxt[DEPTH-1]));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par      <= '0;
      out_perr <= 1'b0;
    end else begin
      par      <= par_nxt;
      out_perr <= perr_nxt;
    end
  end
`else
  logic unused_err_inj;
  assign unused_err_inj = err_inj;
  assign out_perr       = 1'b0;
`endif

endmodule

// File: tb/tb_dff_pipe_line.sv
// Scoreboard bench for dff_pipe_line (WIDTH=8, DEPTH=4); parity vectors run only when PIPE_PARITY_EN is defined.
module tb_dff_pipe_line;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       err_inj = 1'b0;
  logic       out_valid;
  logic [7:0] out_data;
  logic [2:0] occ;
  logic       out_perr;

  int tests = 0;
  int fails = 0;
  logic [8:0] exp_q[$];
  logic       adv;

  dff_pipe_line #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .in_valid(in_valid),
    .in_data(in_data), .err_inj(err_inj), .out_valid(out_valid),
    .out_data(out_data), .occ(occ), .out_perr(out_perr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: after every advancing edge, a valid output must match the head of the scoreboard.
  always begin
    @(posedge clk);
    adv = en && !clr && !rst;
    @(negedge clk);
    if (adv && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", {23'd0, out_perr, out_data}, 32'h1ff);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        chk("sb_data", 32'(out_data), 32'(e[7:0]));
        chk("sb_perr", 32'(out_perr), 32'(e[8]));
      end
    end else if (!rst) begin
      chk("perr_when_invalid", 32'(out_perr && !out_valid), 32'd0);
    end
  end

  // Called at a negedge; returns at the following negedge.
  task automatic step(input logic e, input logic c, input logic v, input logic [7:0] d, input logic ei);
    logic pe;
`ifdef PIPE_PARITY_EN
    pe = ei;
`else
    pe = 1'b0;
`endif
    en = e; clr = c; in_valid = v; in_data = d; err_inj = ei;
    if (e && !c && v) exp_q.push_back({pe, d});
    @(posedge clk);
    if (c) exp_q.delete();
    @(negedge clk);
  endtask

  initial begin
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_data", 32'(out_data), 32'd0);
    chk("reset_occ", 32'(occ), 32'd0);
    chk("reset_out_perr", 32'(out_perr), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Latency and ordering
    step(1, 0, 1, 8'h11, 0); chk("lat_occ1", 32'(occ), 32'd1);
    step(1, 0, 1, 8'h22, 0); chk("lat_occ2", 32'(occ), 32'd2);
    step(1, 0, 1, 8'h33, 0); chk("lat_occ3", 32'(occ), 32'd3);
    chk("lat_not_yet_valid", 32'(out_valid), 32'd0);
    step(1, 0, 1, 8'h44, 0); chk("lat_occ4", 32'(occ), 32'd4);
    chk("lat_first_valid", 32'(out_valid), 32'd1);
    chk("lat_first_data", 32'(out_data), 32'h11);
    step(1, 0, 1, 8'h55, 0); chk("lat_occ_sat", 32'(occ), 32'd4);
    chk("lat_second_data", 32'(out_data), 32'h22);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 8'h00, 0);
      chk("drain_occ", 32'(occ), 32'(3 - i));
    end

    // Stall: en=0 holds everything and drops the offered 0xFF
    step(1, 0, 1, 8'h11, 0); step(1, 0, 1, 8'h22, 0);
    step(1, 0, 1, 8'h33, 0); step(1, 0, 1, 8'h44, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 8'hFF, 0);
      chk("stall_data", 32'(out_data), 32'h11);
      chk("stall_occ", 32'(occ), 32'd4);
      chk("stall_valid", 32'(out_valid), 32'd1);
    end
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 8'h00, 0);
      chk("stall_drain_occ", 32'(occ), 32'(3 - i));
    end

    // Bubbles: valid / invalid / valid
    step(1, 0, 1, 8'h01, 0); chk("bub_occ1", 32'(occ), 32'd1);
    step(1, 0, 0, 8'h02, 0); chk("bub_occ2", 32'(occ), 32'd1);
    step(1, 0, 1, 8'h03, 0); chk("bub_occ3", 32'(occ), 32'd2);
    step(1, 0, 0, 8'h00, 0); chk("bub_occ4", 32'(occ), 32'd2);
    chk("bub_valid_a", 32'(out_valid), 32'd1);
    step(1, 0, 0, 8'h00, 0); chk("bub_valid_b", 32'(out_valid), 32'd0);
    chk("bub_invalid_data_kept", 32'(out_data), 32'h02);
    step(1, 0, 0, 8'h00, 0); chk("bub_valid_c", 32'(out_valid), 32'd1);
    step(1, 0, 0, 8'h00, 0); chk("bub_empty", 32'(occ), 32'd0);

    // Flush with en=1 and a valid input on the same edge
    step(1, 0, 1, 8'hA1, 0); step(1, 0, 1, 8'hA2, 0);
    step(1, 0, 1, 8'hA3, 0); step(1, 0, 1, 8'hA4, 0);
    chk("flush_full", 32'(occ), 32'd4);
    step(1, 1, 1, 8'h99, 0);
    chk("flush_occ", 32'(occ), 32'd0);
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_data", 32'(out_data), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 8'h00, 0);
      chk("flush_no_99", 32'(out_valid), 32'd0);
    end

    // Asynchronous reset mid-stream
    for (int i = 0; i < 4; i++) step(1, 0, 1, 8'hA5, 0);
    chk("pre_rst_data", 32'(out_data), 32'hA5);
    en = 1'b0; in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_data", 32'(out_data), 32'd0);
    chk("arst_occ", 32'(occ), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    step(1, 0, 0, 8'h00, 0);
    chk("post_rst_valid", 32'(out_valid), 32'd0);

`ifdef PIPE_PARITY_EN
    step(1, 0, 1, 8'h0F, 1);
    step(1, 0, 1, 8'h0F, 0);
    step(1, 0, 0, 8'h00, 0);
    step(1, 0, 0, 8'h00, 0);
    chk("par_first_perr", 32'(out_perr), 32'd1);
    step(1, 0, 0, 8'h00, 0);
    chk("par_second_perr", 32'(out_perr), 32'd0);
    step(1, 0, 0, 8'h00, 0);
    chk("par_idle_perr", 32'(out_perr), 32'd0);
`endif

    for (int i = 0; i < 5; i++) step(1, 0, 0, 8'h00, 0);
    chk("sb_empty_at_end", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
